// File: rtl/butterfly_pkg.sv
// butterfly_pkg: width helpers shared by the butterfly top and its complex multiplier
package butterfly_pkg;
  localparam int DEF_WIDTH    = 16;
  localparam int DEF_TW_WIDTH = 10;
  // Sum/difference width: one growth bit over the input samples
  function automatic int sum_w(input int w);
    return w + 1;
  endfunction
  // Full-precision product width of a difference and a twiddle component
  function automatic int prod_w(input int w, input int tw);
    return w + 1 + tw;
  endfunction
  // y2 output width; holds |d*W| for |W| <= 1 without overflow
  function automatic int out_w(input int w);
    return w + 3;
  endfunction
  // Twiddle fractional bits (Q2.TW_FRAC)
  function automatic int tw_frac(input int tw);
    return tw - 2;
  endfunction
endpackage

// File: rtl/butterfly_cmplx_mult.sv
// cmplx_mult: two-stage complex multiply (d * W) with Q2 scaling; rounding under BUTTERFLY_ROUND_EN
module cmplx_mult
  import butterfly_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int TW_WIDTH = DEF_TW_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              en1_i,
  input  logic                              en2_i,
  input  logic signed [sum_w(WIDTH)-1:0]    dr_i,
  input  logic signed [sum_w(WIDTH)-1:0]    di_i,
  input  logic signed [TW_WIDTH-1:0]        wr_i,
  input  logic signed [TW_WIDTH-1:0]        wi_i,
  output logic signed [out_w(WIDTH)-1:0]    re_o,
  output logic signed [out_w(WIDTH)-1:0]    im_o
);
  localparam int SUM_W   = sum_w(WIDTH);
  localparam int PROD_W  = prod_w(WIDTH, TW_WIDTH);
  localparam int ACC_W   = PROD_W + 1;
  localparam int OUT_W   = out_w(WIDTH);
  localparam int TW_FRAC = tw_frac(TW_WIDTH);
`ifdef BUTTERFLY_ROUND_EN
  localparam int RND_I = 1 << (TW_FRAC - 1);
`else
  localparam int RND_I = 0;
`endif
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(RND_I);

  logic signed [PROD_W-1:0] rr_d, ii_d, ri_d, ir_d;
  logic signed [PROD_W-1:0] rr_q, ii_q, ri_q, ir_q;
  logic signed [ACC_W-1:0]  re_acc, im_acc;
  logic signed [OUT_W-1:0]  re_d, im_d, re_q, im_q;

  // Operands are widened to the full product width so each product is exact
  always_comb begin
    rr_d   = PROD_W'(dr_i) * PROD_W'(wr_i);
    ii_d   = PROD_W'(di_i) * PROD_W'(wi_i);
    ri_d   = PROD_W'(dr_i) * PROD_W'(wi_i);
    ir_d   = PROD_W'(di_i) * PROD_W'(wr_i);
    re_acc = ACC_W'(rr_q) - ACC_W'(ii_q) + RND;
    im_acc = ACC_W'(ri_q) + ACC_W'(ir_q) + RND;
    re_d   = OUT_W'(re_acc >>> TW_FRAC);
    im_d   = OUT_W'(im_acc >>> TW_FRAC);
  end

  // Product register stage, loads with its stage valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= '0;
      ii_q <= '0;
      ri_q <= '0;
      ir_q <= '0;
    end else if (en1_i) begin
      rr_q <= rr_d;
      ii_q <= ii_d;
      ri_q <= ri_d;
      ir_q <= ir_d;
    end
  end

  // Combine, scale and register the result; holds while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      re_q <= '0;
      im_q <= '0;
    end else if (en2_i) begin
      re_q <= re_d;
      im_q <= im_d;
    end
  end

  assign re_o = re_q;
  assign im_o = im_q;
endmodule

// File: rtl/butterfly.sv
// butterfly: radix-2 DIF FFT butterfly, y1 = a+b, y2 = (a-b)*W, 3-cycle latency; BUTTERFLY_ROUND_EN selects rounding
module butterfly
  import butterfly_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int TW_WIDTH = DEF_TW_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic signed [WIDTH-1:0]        a_real,
  input  logic signed [WIDTH-1:0]        a_imag,
  input  logic signed [WIDTH-1:0]        b_real,
  input  logic signed [WIDTH-1:0]        b_imag,
  input  logic signed [TW_WIDTH-1:0]     twiddle_real,
  input  logic signed [TW_WIDTH-1:0]     twiddle_imag,
  input  logic                           i_valid,
  output logic signed [WIDTH:0]          y1_real,
  output logic signed [WIDTH:0]          y1_imag,
  output logic signed [WIDTH+2:0]        y2_real,
  output logic signed [WIDTH+2:0]        y2_imag,
  output logic                           o_valid
);
  localparam int SUM_W = sum_w(WIDTH);

  logic [2:0]                v_q;
  logic signed [SUM_W-1:0]   sr_d, si_d, dr_d, di_d;
  logic signed [SUM_W-1:0]   sr_q, si_q, dr_q, di_q;
  logic signed [SUM_W-1:0]   s2r_q, s2i_q, y1r_q, y1i_q;
  logic signed [TW_WIDTH-1:0] wr_q, wi_q;

  always_comb begin
    sr_d = SUM_W'(a_real) + SUM_W'(b_real);
    si_d = SUM_W'(a_imag) + SUM_W'(b_imag);
    dr_d = SUM_W'(a_real) - SUM_W'(b_real);
    di_d = SUM_W'(a_imag) - SUM_W'(b_imag);
  end

  // Valid shift register: o_valid is i_valid delayed by exactly three edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) v_q <= '0;
    else        v_q <= {v_q[1:0], i_valid};
  end

  // Stage 1: sum, difference and the twiddle that travels with them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
      si_q <= '0;
      dr_q <= '0;
      di_q <= '0;
      wr_q <= '0;
      wi_q <= '0;
    end else if (i_valid) begin
      sr_q <= sr_d;
      si_q <= si_d;
      dr_q <= dr_d;
      di_q <= di_d;
      wr_q <= twiddle_real;
      wi_q <= twiddle_imag;
    end
  end

  // y1 delay line keeping the sum aligned with the multiplier output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2r_q <= '0;
      s2i_q <= '0;
      y1r_q <= '0;
      y1i_q <= '0;
    end else begin
      if (v_q[0]) begin
        s2r_q <= sr_q;
        s2i_q <= si_q;
      end
      if (v_q[1]) begin
        y1r_q <= s2r_q;
        y1i_q <= s2i_q;
      end
    end
  end

  cmplx_mult #(.WIDTH(WIDTH), .TW_WIDTH(TW_WIDTH)) u_mult (
    .clk   (clk),
    .rst_n (rst_n),
    .en1_i (v_q[0]),
    .en2_i (v_q[1]),
    .dr_i  (dr_q),
    .di_i  (di_q),
    .wr_i  (wr_q),
    .wi_i  (wi_q),
    .re_o  (y2_real),
    .im_o  (y2_imag)
  );

  assign y1_real = y1r_q;
  assign y1_imag = y1i_q;
  assign o_valid = v_q[2];
endmodule

// File: tb/tb_butterfly.sv
// tb_butterfly: scoreboard bench for butterfly, directed cases plus randomized stream against a real-valued model
module tb_butterfly;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic signed [15:0] a_real = '0, a_imag = '0, b_real = '0, b_imag = '0;
  logic signed [9:0]  twiddle_real = '0, twiddle_imag = '0;
  logic               i_valid = 1'b0;
  logic signed [16:0] y1_real, y1_imag;
  logic signed [18:0] y2_real, y2_imag;
  logic               o_valid;

  typedef struct {
    longint y1r, y1i;
    real    y2r, y2i, tol;
    int     cyc;
  } exp_t;

  exp_t   sb[$];
  int     total = 0, bad = 0, cyc = 0, n_in = 0, n_out = 0;
  bit     seen = 0;
  longint last_y1r, last_y1i, last_y2r, last_y2i;

  butterfly dut (
    .clk(clk), .rst_n(rst_n),
    .a_real(a_real), .a_imag(a_imag), .b_real(b_real), .b_imag(b_imag),
    .twiddle_real(twiddle_real), .twiddle_imag(twiddle_imag), .i_valid(i_valid),
    .y1_real(y1_real), .y1_imag(y1_imag), .y2_real(y2_real), .y2_imag(y2_imag),
    .o_valid(o_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1);
  end

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic chk_tol(input string name, input longint act, input real req, input real tol);
    real d;
    d = $itor(act) - req;
    if (d < 0.0) d = -d;
    total++;
    if (d > tol) begin
      bad++;
      $display("FAIL %s: got %0d, required %f +/- %f", name, act, req, tol);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a result
  always @(negedge clk) begin
    if (!rst_n) seen = 0;
    else if (o_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got o_valid=1, required 0 at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("latency", cyc, e.cyc);
        chk("y1_real", y1_real, e.y1r);
        chk("y1_imag", y1_imag, e.y1i);
        chk_tol("y2_real", y2_real, e.y2r, e.tol);
        chk_tol("y2_imag", y2_imag, e.y2i, e.tol);
        n_out++;
        seen = 1;
        last_y1r = y1_real; last_y1i = y1_imag;
        last_y2r = y2_real; last_y2i = y2_imag;
      end
    end else if (seen) begin
      chk("hold_y1_real", y1_real, last_y1r);
      chk("hold_y2_imag", y2_imag, last_y2i);
    end
  end

  // Drive one sample on the next falling edge and queue its expected result
  task automatic issue(input int ar, ai, br, bi, wr, wi, input real e2r, e2i, tol);
    exp_t e;
    @(negedge clk);
    a_real = 16'(ar); a_imag = 16'(ai); b_real = 16'(br); b_imag = 16'(bi);
    twiddle_real = 10'(wr); twiddle_imag = 10'(wi);
    i_valid = 1'b1;
    e.y1r = ar + br; e.y1i = ai + bi;
    e.y2r = e2r; e.y2i = e2i; e.tol = tol;
    e.cyc = cyc + 3;
    sb.push_back(e);
    n_in++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      i_valid = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    chk("drain_queue_empty", sb.size(), 0);
  endtask

  // Exact complex arithmetic: (a-b)*W with W in units of 1/256
  function automatic void ref_y2(input int ar, ai, br, bi, wr, wi, output real r, output real im);
    real dr, di, fr, fi;
    dr = ar - br; di = ai - bi;
    fr = wr / 256.0; fi = wi / 256.0;
    r  = dr * fr - di * fi;
    im = dr * fi + di * fr;
  endfunction

  initial begin
    real r, im;
    int  ar, ai, br, bi, wr, wi;
    repeat (2) @(negedge clk);
    chk("reset_o_valid", o_valid, 0);
    chk("reset_y1_real", y1_real, 0);
    chk("reset_y1_imag", y1_imag, 0);
    chk("reset_y2_real", y2_real, 0);
    chk("reset_y2_imag", y2_imag, 0);
    rst_n = 1'b1;
    idle(2);

    issue(100, 50, 20, 10, 256, 0, 80.0, 40.0, 0.0);
    idle(4);
    issue(100, 50, 20, 10, 0, 256, -40.0, 80.0, 0.0);
    issue(32767, 32767, -32768, -32768, -256, -256, 0.0, -131070.0, 0.0);
`ifdef BUTTERFLY_ROUND_EN
    issue(3, 0, 0, 0, 128, 0, 2.0, 0.0, 0.0);
`else
    issue(3, 0, 0, 0, 128, 0, 1.0, 0.0, 0.0);
`endif
    idle(1);
    drain();

    issue(1000, -2000, 300, 400, 181, -181, 0.0, 0.0, 1.0e9);
    issue(-5, 7, 9, -11, 256, 0, 0.0, 0.0, 1.0e9);
    @(negedge clk);
    i_valid = 1'b0;
    #2 rst_n = 1'b0;
    sb.delete();
    n_in = n_in - 2;
    #1;
    chk("midreset_o_valid", o_valid, 0);
    chk("midreset_y1_real", y1_real, 0);
    chk("midreset_y2_real", y2_real, 0);
    chk("midreset_y2_imag", y2_imag, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    idle(6);

    for (int n = 0; n < 300; n++) begin
      ar = int'($signed(16'($urandom))); ai = int'($signed(16'($urandom)));
      br = int'($signed(16'($urandom))); bi = int'($signed(16'($urandom)));
      wr = int'($urandom_range(512)) - 256;
      wi = int'($urandom_range(512)) - 256;
      ref_y2(ar, ai, br, bi, wr, wi, r, im);
      issue(ar, ai, br, bi, wr, wi, r, im, 2.0);
      idle(int'($urandom_range(4)));
    end
    idle(1);
    drain();
    chk("valid_count", n_out, n_in);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
